load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the word-addressed core memory. It turns RISC-V data-memory requests (LB/LH/LW/LBU/LHU/SB/SH/SW) from the execute stage into word reads and writes on the memory's read/write ports. It extracts bytes and halfwords and sign- or zero-extends them for loads. It performs byte and halfword stores as read-modify-write, because the memory writes whole words only. Misaligned, illegal and out-of-range accesses are flagged as faults.

## Interface
Parameters:
- MEMORY_WORDS, default 1 << 16: word capacity of the attached memory; a word index at or above this value faults.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (size/sign).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (low byte/half used for SB/SH).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  access rejected; qualified by rsp_valid.
- mem_ra  out  32  memory read byte address (bits [1:0] always 0).
- mem_rd  in  32  memory read data, combinational from mem_ra in the same cycle.
- mem_we  out  1  memory write enable.
- mem_wa  out  32  memory write byte address (bits [1:0] always 0).
- mem_wd  out  32  memory write data.

## Operation
- States: IDLE, WRITE, RESP.
- req_ready = (state == IDLE). A request is accepted on a cycle with req_valid && req_ready.
- No response backpressure: rsp_valid is high exactly one cycle, and only in RESP.

Fault check on the accept cycle (combinational on the request):
- Illegal funct3: loads 3, 6, 7; stores ≥ 3.
- Misaligned: H/HU/SH with addr[0] = 1; W/SW with addr[1:0] ≠ 0.
- Out of range: addr[31:2] ≥ MEMORY_WORDS.
- On a fault: no memory write; go to RESP with rsp_fault = 1 and rsp_rdata = 0.

Load path:
- In IDLE, mem_ra = {req_addr[31:2], 2'b00}.
- Select the lane by addr[1:0]. Byte k is mem_rd[8k+7:8k]; the half at offset 2 is mem_rd[31:16].
- Sign-extend for LB/LH; zero-extend for LBU/LHU.
- Register the result into rsp_rdata and go to RESP.

Store path:
- On accept, merge into the word at mem_ra:
  - SB replaces byte addr[1:0] with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - SW takes wdata whole.
- Register the word address and the merged word, then go to WRITE.
- WRITE: mem_we = 1, mem_wa = registered address, mem_wd = merged word. Next state RESP.
- RESP: rsp_fault = 0, rsp_rdata = 0. Next state IDLE.

Port behaviour outside these cases:
- mem_ra outside IDLE holds the registered word address.
- mem_we = 0 in every state except WRITE.

## Timing
- Load or fault accepted at cycle T: rsp_valid at T+1; req_ready high again at T+2.
- Store accepted at T: mem_we at T+1; the memory updates at the end of T+1; rsp_valid at T+2; next accept at T+3.
- A load accepted at T+3 after a store observes the stored data.
- Read data is sampled in the accept cycle. The RMW window has one unit and a single master, so no other writer can intervene.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_fault 0, mem_we 0, mem_wa 0, mem_wd 0, mem_ra follows req_addr.
- Reset asserted in WRITE: mem_we drops immediately (asynchronous), the pending write is discarded, and no response is issued.
- Reset asserted in RESP: the response is dropped.

## Structure
- Package lsu_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State enum lsu_state_t {IDLE, WRITE, RESP}.
- Sub-module load_align (combinational): inputs word, addr[1:0], funct3; outputs extended data. It reuses the same lane decode as the store merge.

## Test plan
Memory preload: word at 0x100 = 0x876543A1.

1. LB 0x103 -> rsp_rdata 0xFFFFFF87 at T+1. LBU 0x103 -> 0x00000087. LH 0x100 -> 0x000043A1. LHU 0x102 -> 0x00008765.
2. SB 0x102, wdata 0x1234565A -> at T+1: mem_we=1, mem_wa=0x100, mem_wd=0x875A43A1. rsp_valid at T+2 with fault 0. Following LW 0x100 returns 0x875A43A1.
3. SH 0x101, LW 0x102, and a load with funct3=3 -> each gives rsp_fault=1 and rsp_rdata=0 at T+1. mem_we never asserts.
4. With MEMORY_WORDS = 1<<16, LW 0x00040000 -> fault. LW 0x0003FFFC -> no fault.
5. req_valid held high with loads to 0x100 and 0x104 -> accepts at T and T+2; rsp_valid at T+1 and T+3; req_ready low at T+1.
6. Reset asserted during the WRITE cycle of an SW 0x100 with wdata 0xDEADBEEF -> mem_we falls the same cycle. After release, LW 0x100 still returns 0x876543A1, no rsp_valid is seen from the aborted store, and req_ready = 1.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// lsu_pkg: funct3 encodings, FSM states and the byte-lane helpers shared by
// the load aligner and the store merge.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } lsu_state_t;

  // Byte offset of the accessed lane inside the word; halfwords snap to 0 or 2.
  function automatic logic [1:0] lane_offset(input logic [2:0] funct3,
                                             input logic [1:0] addr);
    logic [1:0] off;
    case (funct3[1:0])
      2'd0:    off = addr;
      2'd1:    off = {addr[1], 1'b0};
      default: off = 2'd0;
    endcase
    return off;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  addr);
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] merged;
    off = lane_offset(funct3, addr);
    case (funct3[1:0])
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0011;
      default: be = 4'b1111;
    endcase
    be   = be << off;
    data = wdata << {off, 3'b000};
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? data[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// load_align: picks the addressed byte/halfword out of a memory word and
// sign- or zero-extends it according to funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = word >> {lane_offset(funct3, addr), 3'b000};

  always_comb begin
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: RISC-V data-memory initiator for a word-only memory;
// sub-word stores are done as read-modify-write, bad accesses fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEMORY_WORDS = 1 << 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_ra,
  input  logic [31:0] mem_rd,
  output logic        mem_we,
  output logic [31:0] mem_wa,
  output logic [31:0] mem_wd
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEMORY_WORDS);

  lsu_state_t  state, state_next;
  logic [31:0] word_addr;
  logic [31:0] merged_word;
  logic [31:0] rdata_reg;
  logic        fault_reg;
  logic        accept;
  logic        illegal, misaligned, out_of_range, fault;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_ra    = (state == IDLE) ? {req_addr[31:2], 2'b00} : word_addr;

  always_comb begin
    illegal = 1'b0;
    if (req_we) begin
      illegal = (req_funct3 >= 3'd3);
    end else begin
      illegal = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
    end
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign out_of_range = ({3'b000, req_addr[31:2]} >= MEM_LIMIT);
  assign fault        = illegal || misaligned || out_of_range;

  load_align u_load_align (
    .word   (mem_rd),
    .addr   (req_addr[1:0]),
    .funct3 (req_funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (req_we && !fault) ? WRITE : RESP;
        end
      end
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data is captured on the accept cycle; the merge happens right away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_addr   <= 32'd0;
      merged_word <= 32'd0;
      rdata_reg   <= 32'd0;
      fault_reg   <= 1'b0;
    end else if (accept) begin
      word_addr <= {req_addr[31:2], 2'b00};
      fault_reg <= fault;
      rdata_reg <= (fault || req_we) ? 32'd0 : load_data;
      if (req_we && !fault) begin
        merged_word <= store_merge(mem_rd, req_wdata, req_funct3, req_addr[1:0]);
      end
    end
  end

  assign mem_we    = (state == WRITE);
  assign mem_wa    = word_addr;
  assign mem_wd    = merged_word;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_fault = fault_reg;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit: scoreboard bench with a byte-level reference memory,
// directed cases followed by randomized loads and stores.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned MEMORY_WORDS = 1 << 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_ra, mem_rd, mem_wa, mem_wd;
  logic        mem_we;

  load_store_unit #(.MEMORY_WORDS(MEMORY_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_ra(mem_ra), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_wa(mem_wa), .mem_wd(mem_wd)
  );

  always #5 clk = ~clk;

  // Attached word memory
  logic [31:0] mem [0:MEMORY_WORDS-1];
  assign mem_rd = mem[mem_ra[17:2]];
  always @(posedge clk) if (mem_we) mem[mem_wa[17:2]] <= mem_wd;

  // Reference model: plain byte array, little-endian
  logic [7:0] ref_bytes [0:4*MEMORY_WORDS-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic fault; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t mon_rsp;
  wr_t  mon_wr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit ref_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int  nbytes;
    bit  illegal;
    nbytes  = 1 << f3[1:0];
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    return illegal || ((a % nbytes) != 0) || (a[31:2] >= MEMORY_WORDS);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with rdata %h, required no response", rsp_rdata);
        end else begin
          mon_rsp = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata, mon_rsp.rdata);
          check("rsp_fault", 32'(rsp_fault), 32'(mon_rsp.fault));
          check("rsp_cycle", 32'(cyc), 32'(mon_rsp.cyc));
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: mem_we=1 addr %h data %h, required no write", mem_wa, mem_wd);
        end else begin
          mon_wr = wr_q.pop_front();
          check("mem_wa", mem_wa, mon_wr.addr);
          check("mem_wd", mem_wd, mon_wr.data);
          check("write_cycle", 32'(cyc), 32'(mon_wr.cyc));
        end
      end
    end
  end

  // Leaves req_valid high after the accepting edge; idle() drops it.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int          waited;
    int          nbytes;
    int          base;
    bit          f;
    logic [31:0] v;
    rsp_t        r;
    wr_t         w;
    waited = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: req_ready=0 after 20 cycles, required 1");
      return;
    end
    f       = ref_fault(we, f3, a);
    nbytes  = 1 << f3[1:0];
    base    = int'(a[17:0]);
    r.fault = f;
    r.rdata = 32'd0;
    r.cyc   = cyc + 1;
    if (!f && !we) begin
      v = 32'd0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
      if (nbytes < 4 && !f3[2] && v[8*nbytes-1]) v = v | ~((32'd1 << (8 * nbytes)) - 32'd1);
      r.rdata = v;
    end
    if (!f && we) begin
      for (int i = 0; i < nbytes; i++) ref_bytes[base + i] = wd[8*i +: 8];
      base   = base & ~3;
      w.addr = {a[31:2], 2'b00};
      w.data = {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
      w.cyc  = cyc + 1;
      wr_q.push_back(w);
      r.cyc  = cyc + 2;
    end
    rsp_q.push_back(r);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          mism;
    logic [31:0] w;
    logic [2:0]  f3;
    logic [31:0] a;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0000_1237;
    req_wdata  = 32'd0;
    for (int i = 0; i < int'(MEMORY_WORDS); i++) mem[i] = 32'd0;
    for (int i = 0; i < 4 * int'(MEMORY_WORDS); i++) ref_bytes[i] = 8'd0;
    mem[32'h100 >> 2] = 32'h8765_43A1;
    ref_bytes[32'h100] = 8'hA1;
    ref_bytes[32'h101] = 8'h43;
    ref_bytes[32'h102] = 8'h65;
    ref_bytes[32'h103] = 8'h87;

    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_fault", 32'(rsp_fault), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_wa", mem_wa, 32'd0);
    check("reset_mem_wd", mem_wd, 32'd0);
    check("reset_mem_ra", mem_ra, 32'h0000_1234);
    @(posedge clk);
    #1 reset = 1'b0;

    // Sub-word load extraction and extension
    issue(1'b0, F3_B,  32'h103, 32'd0);
    issue(1'b0, F3_BU, 32'h103, 32'd0);
    issue(1'b0, F3_H,  32'h100, 32'd0);
    issue(1'b0, F3_HU, 32'h102, 32'd0);
    idle(1);

    // Byte store RMW then read back
    issue(1'b1, F3_B, 32'h102, 32'h1234_565A);
    issue(1'b0, F3_W, 32'h100, 32'd0);
    idle(1);

    // Faults: misaligned store, misaligned load, illegal funct3, range edge
    issue(1'b1, F3_H,  32'h101, 32'hFFFF_FFFF);
    issue(1'b0, F3_W,  32'h102, 32'd0);
    issue(1'b0, 3'd3,  32'h100, 32'd0);
    issue(1'b0, F3_W,  32'h0004_0000, 32'd0);
    issue(1'b0, F3_W,  32'h0003_FFFC, 32'd0);
    idle(1);

    // Back-to-back loads with req_valid held high
    issue(1'b0, F3_W, 32'h100, 32'd0);
    #1 check("ready_low_after_accept", 32'(req_ready), 32'd0);
    issue(1'b0, F3_W, 32'h104, 32'd0);
    idle(1);

    // Reset during the WRITE cycle of a store drops the write and response
    issue(1'b1, F3_W, 32'h100, 32'h8765_43A1);
    idle(3);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h100;
    req_wdata  = 32'hDEAD_BEEF;
    check("abort_ready_before", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("abort_we_in_write", 32'(mem_we), 32'd1);
    #1 reset = 1'b1;
    #1 check("abort_we_dropped", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_ready_after", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    issue(1'b0, F3_W, 32'h100, 32'd0);
    idle(1);

    // Randomized traffic
    for (int k = 0; k < 250; k++) begin
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0:       f3 = F3_B;
          1:       f3 = F3_H;
          2:       f3 = F3_W;
          3:       f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
      end
      if ($urandom_range(0, 9) == 0) a = 32'h0004_0000 | $urandom;
      else a = 32'h100 + 32'($urandom_range(0, 63));
      if (f3[2] && $urandom_range(0, 1) == 0) f3 = {1'b0, f3[1:0]};
      issue($urandom_range(0, 1) == 1, f3, a, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
    end
    idle(5);

    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("write_queue_drained", 32'(wr_q.size()), 32'd0);
    mism = 0;
    for (int i = 32'h100; i < 32'h140; i += 4) begin
      w = {ref_bytes[i + 3], ref_bytes[i + 2], ref_bytes[i + 1], ref_bytes[i]};
      if (mem[i >> 2] !== w) mism++;
    end
    check("memory_image_mismatches", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
